// File: rtl/painterengine_gpu_dma_reader.sv
// Read DMA for the display streamer: splits an address/length job into AXI4
// read bursts (max-burst and 4 KB page limited) and streams words to the pixel FIFO.
module painterengine_gpu_dma_reader #(
  parameter int PARAM_MAX_BURST  = 16,
  parameter int PARAM_ADDR_WIDTH = 32
) (
  input  logic                        i_wire_clock,
  input  logic                        i_wire_reset,
  input  logic                        i_wire_enable,
  input  logic [PARAM_ADDR_WIDTH-1:0] i_wire_address,
  input  logic [31:0]                 i_wire_length,
  output logic                        o_wire_done,
  output logic                        o_wire_error,
  output logic [31:0]                 o_wire_data,
  output logic                        o_wire_data_valid,
  input  logic                        i_wire_data_next,
  output logic [PARAM_ADDR_WIDTH-1:0] o_wire_araddr,
  output logic [7:0]                  o_wire_arlen,
  output logic                        o_wire_arvalid,
  input  logic                        i_wire_arready,
  input  logic [31:0]                 i_wire_rdata,
  input  logic [1:0]                  i_wire_rresp,
  input  logic                        i_wire_rlast,
  input  logic                        i_wire_rvalid,
  output logic                        o_wire_rready
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  localparam logic [31:0] LP_MAX_BURST = 32'(PARAM_MAX_BURST);

  // Beats for the next burst; addresses are word aligned, so page room is 1024 - word index.
  function automatic logic [8:0] f_burst_beats(input logic [9:0] word_in_page,
                                               input logic [31:0] remaining);
    logic [31:0] page_words;
    logic [31:0] beats;
    page_words = 32'd1024 - {22'd0, word_in_page};
    beats      = (remaining > LP_MAX_BURST) ? LP_MAX_BURST : remaining;
    beats      = (beats > page_words) ? page_words : beats;
    return 9'(beats);
  endfunction

  logic [2:0]                  r_state;
  logic [PARAM_ADDR_WIDTH-1:0] r_addr;
  logic [31:0]                 r_remaining;
  logic                        r_drain_err;
  logic                        r_armed;
  logic                        r_done;
  logic                        r_error;
  logic                        r_arvalid;
  logic [PARAM_ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]                  r_arlen;

  logic [9:0]  w_src_word;
  logic [31:0] w_src_rem;
  logic [8:0]  w_next_beats;
  logic [7:0]  w_next_arlen;
  logic [8:0]  w_ar_beats;
  logic        w_ar_fire;
  logic        w_r_fire;
  logic        w_rready;
  logic        w_in_data;
  logic        w_resp_err;

  // Burst sizing source: job inputs when starting, internal counters otherwise.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_src_word = i_wire_address[11:2];
      w_src_rem  = i_wire_length;
    end else begin
      w_src_word = r_addr[11:2];
      w_src_rem  = r_remaining;
    end
    w_next_beats = f_burst_beats(w_src_word, w_src_rem);
    w_next_arlen = 8'(w_next_beats - 9'd1);
    w_ar_beats   = {1'b0, r_arlen} + 9'd1;
  end

  // Read-channel handshake; data passes straight through while a burst is live.
  always_comb begin
    w_in_data  = (r_state == S_DATA);
    w_resp_err = (i_wire_rresp != 2'b00);
    if (r_state == S_DATA) begin
      w_rready = i_wire_data_next;
    end else begin
      w_rready = (r_state == S_DRAIN);
    end
    w_ar_fire = r_arvalid && i_wire_arready;
    w_r_fire  = i_wire_rvalid && w_rready;
  end

  assign o_wire_rready      = w_rready;
  assign o_wire_data_valid  = w_in_data && i_wire_rvalid && i_wire_data_next && !w_resp_err;
  assign o_wire_data        = w_in_data ? i_wire_rdata : 32'd0;
  assign o_wire_done        = r_done;
  assign o_wire_error       = r_error;
  assign o_wire_arvalid     = r_arvalid;
  assign o_wire_araddr      = r_araddr;
  assign o_wire_arlen       = r_arlen;

  // Job sequencer. r_armed records that enable was low in IDLE on the previous cycle.
  always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
    if (i_wire_reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= 32'd0;
      r_drain_err <= 1'b0;
      r_armed     <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_arvalid   <= 1'b0;
      r_araddr    <= '0;
      r_arlen     <= 8'd0;
    end else begin
      r_armed <= (r_state == S_IDLE) && !i_wire_enable;
      case (r_state)
        S_IDLE: begin
          if (i_wire_enable && r_armed) begin
            r_addr      <= i_wire_address;
            r_remaining <= i_wire_length;
            if (i_wire_address[1:0] != 2'b00) begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end else if (i_wire_length == 32'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state   <= S_ADDR;
              r_arvalid <= 1'b1;
              r_araddr  <= i_wire_address;
              r_arlen   <= w_next_arlen;
            end
          end
        end
        S_ADDR: begin
          if (w_ar_fire) begin
            r_arvalid   <= 1'b0;
            r_addr      <= r_addr + {{(PARAM_ADDR_WIDTH-11){1'b0}}, w_ar_beats, 2'b00};
            r_remaining <= r_remaining - {23'd0, w_ar_beats};
            r_drain_err <= 1'b0;
            r_state     <= i_wire_enable ? S_DATA : S_DRAIN;
          end else if (!i_wire_enable) begin
            r_arvalid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        S_DATA: begin
          if (w_r_fire) begin
            if (!i_wire_enable) begin
              r_drain_err <= 1'b0;
              r_state     <= i_wire_rlast ? S_IDLE : S_DRAIN;
            end else if (w_resp_err) begin
              if (i_wire_rlast) begin
                r_state <= S_ERROR;
                r_error <= 1'b1;
              end else begin
                r_state     <= S_DRAIN;
                r_drain_err <= 1'b1;
              end
            end else if (i_wire_rlast) begin
              if (r_remaining == 32'd0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state   <= S_ADDR;
                r_arvalid <= 1'b1;
                r_araddr  <= r_addr;
                r_arlen   <= w_next_arlen;
              end
            end
          end else if (!i_wire_enable) begin
            r_drain_err <= 1'b0;
            r_state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (i_wire_rvalid && i_wire_rlast) begin
            if (r_drain_err) begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_DONE: begin
          if (!i_wire_enable) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end
        S_ERROR: begin
          if (!i_wire_enable) begin
            r_state <= S_IDLE;
            r_error <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_done    <= 1'b0;
          r_error   <= 1'b0;
          r_arvalid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
// Scoreboard bench: an AXI read slave model serves a synthetic memory, and a
// burst/word reference computed from the job parameters is checked by a monitor.
module tb_painterengine_gpu_dma_reader;

  localparam int MAXB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] address;
  logic [31:0] length;
  logic        done, error;
  logic [31:0] data;
  logic        data_valid;
  logic        next;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  always #5 clk = ~clk;

  painterengine_gpu_dma_reader #(.PARAM_MAX_BURST(MAXB), .PARAM_ADDR_WIDTH(32)) dut (
    .i_wire_clock(clk), .i_wire_reset(rst), .i_wire_enable(enable),
    .i_wire_address(address), .i_wire_length(length),
    .o_wire_done(done), .o_wire_error(error), .o_wire_data(data),
    .o_wire_data_valid(data_valid), .i_wire_data_next(next),
    .o_wire_araddr(araddr), .o_wire_arlen(arlen), .o_wire_arvalid(arvalid),
    .i_wire_arready(arready), .i_wire_rdata(rdata), .i_wire_rresp(rresp),
    .i_wire_rlast(rlast), .i_wire_rvalid(rvalid), .o_wire_rready(rready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [39:0] exp_bursts[$];
  logic [31:0] exp_words[$];

  logic [31:0] sl_addr = 32'd0;
  int          sl_len = 0, sl_idx = 0;
  bit          sl_active = 1'b0, pend_ar = 1'b0, pend_r = 1'b0;
  logic [31:0] cap_addr = 32'd0;
  logic [7:0]  cap_len = 8'd0;
  int          phase = 0, nmode = 0, err_beat = 0;
  bit          sl_rand = 1'b0, chk_rready = 1'b0;
  int          cyc = 0, last_rlast_edge = -1, job_edge = -1, words_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual %h required nothing", name, act);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Reference: the bursts and words a job should produce, stopping after max_words.
  task automatic model_job(input logic [31:0] addr, input logic [31:0] len, input int max_words);
    logic [31:0] a, rem, b, room;
    int pushed;
    a = addr; rem = len; pushed = 0;
    while (rem != 32'd0 && pushed < max_words) begin
      room = (32'd4096 - {20'd0, a[11:0]}) / 32'd4;
      b = (rem > 32'(MAXB)) ? 32'(MAXB) : rem;
      if (b > room) b = room;
      exp_bursts.push_back({a, 8'(b - 32'd1)});
      for (int i = 0; i < int'(b); i++) begin
        if (pushed < max_words) exp_words.push_back(mem_word(a + 32'(4 * i)));
        pushed++;
      end
      a = a + 32'd4 * b;
      rem = rem - b;
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: compares what will be transferred at the coming clock edge.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      pend_ar = 1'b0;
      pend_r  = 1'b0;
    end else begin
      pend_ar = arvalid && arready;
      pend_r  = rvalid && rready;
      if (pend_ar) begin
        cap_addr = araddr;
        cap_len  = arlen;
        if (exp_bursts.size() == 0) fail_now("ar_unexpected", {araddr, arlen});
        else chk("ar_burst", {araddr, arlen}, exp_bursts.pop_front());
      end
      if (data_valid) begin
        words_seen++;
        if (exp_words.size() == 0) fail_now("word_unexpected", data);
        else chk("rd_word", data, exp_words.pop_front());
      end
      if (pend_r && rlast) last_rlast_edge = cyc + 1;
      if (chk_rready && sl_active) chk("rready_tracks_next", rready, next);
      if (done && error) fail_now("done_and_error", {done, error});
    end
  end

  // AXI slave model and consumer: drives the next cycle's inputs after the edge.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      sl_active = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      rdata = 32'd0; arready = 1'b0; next = 1'b1;
    end else begin
      if (pend_r) begin
        sl_idx++;
        if (sl_idx == sl_len) sl_active = 1'b0;
        rvalid = 1'b0;
      end
      if (pend_ar) begin
        if (sl_active) fail_now("ar_while_outstanding", cap_addr);
        sl_active = 1'b1; sl_addr = cap_addr; sl_len = int'(cap_len) + 1; sl_idx = 0;
      end
      if (!sl_active) rvalid = 1'b0;
      else if (!rvalid) rvalid = sl_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      rdata   = rvalid ? mem_word(sl_addr + 32'(4 * sl_idx)) : $urandom;
      rlast   = rvalid && (sl_idx == sl_len - 1);
      rresp   = (rvalid && err_beat != 0 && sl_idx + 1 == err_beat) ? 2'b10 : 2'b00;
      arready = sl_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      case (nmode)
        1:       next = (phase % 4 == 0) || (phase % 4 == 3);
        2:       next = 1'($urandom_range(0, 1));
        default: next = 1'b1;
      endcase
      phase++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_raw(input logic [31:0] addr, input logic [31:0] len);
    address = addr; length = len; enable = 1'b1;
    job_edge = cyc + 1;
  endtask

  task automatic start_job(input logic [31:0] addr, input logic [31:0] len, input int max_words);
    model_job(addr, len, max_words);
    start_raw(addr, len);
  endtask

  // tmode 1: status expected on the edge of the last rlast; 2: on the edge after enable.
  task automatic finish_job(input logic exp_done, input logic exp_err, input int tmode);
    int t;
    t = 0;
    while (!(done || error) && t < 3000) begin
      tick();
      t++;
    end
    if (t >= 3000) fail_now("job_timeout", {done, error});
    else begin
      chk("job_status", {done, error}, {exp_done, exp_err});
      if (tmode == 1) chk("status_after_rlast", cyc, last_rlast_edge);
      if (tmode == 2) chk("status_after_enable", cyc, job_edge);
    end
    chk("words_left", exp_words.size(), 0);
    chk("bursts_left", exp_bursts.size(), 0);
    chk("slave_idle", sl_active, 0);
    repeat (3) tick();
    chk("status_held", {done, error}, {exp_done, exp_err});
    enable = 1'b0;
    tick();
    chk("status_cleared", {done, error}, 2'b00);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t, base;
    logic [31:0] r, a;
    rst = 1'b1; enable = 1'b0; address = 32'd0; length = 32'd0;
    #12;
    chk("reset_outputs", {done, error, data_valid, arvalid, rready, araddr, arlen, data},
        {5'd0, 32'd0, 8'd0, 32'd0});
    @(negedge clk);
    rst = 1'b0;
    tick(); tick();

    start_job(32'h0000_1000, 32'd40, 1000);   finish_job(1'b1, 1'b0, 1);
    start_job(32'h0000_0FF8, 32'd5, 1000);    finish_job(1'b1, 1'b0, 1);

    nmode = 1; chk_rready = 1'b1;
    start_job(32'h0000_6000, 32'd16, 1000);   finish_job(1'b1, 1'b0, 1);
    nmode = 0; chk_rready = 1'b0;

    err_beat = 3;
    start_job(32'h0000_3000, 32'd16, 2);      finish_job(1'b0, 1'b1, 1);
    err_beat = 0;

    start_job(32'h0000_7000, 32'd0, 1000);    finish_job(1'b1, 1'b0, 2);
    start_raw(32'h0000_1002, 32'd8);          finish_job(1'b0, 1'b1, 2);
    start_job(32'hFFFF_FFF8, 32'd4, 1000);    finish_job(1'b1, 1'b0, 1);

    // Abort after four delivered words; the rest of the burst must drain silently.
    base = words_seen;
    start_job(32'h0000_4000, 32'd16, 1000);
    t = 0;
    while (words_seen - base < 4 && t < 1000) begin
      @(negedge clk); #3; t++;
    end
    enable = 1'b0;
    exp_words.delete();
    t = 0;
    do begin tick(); t++; end while ((sl_active || rvalid) && t < 1000);
    tick();
    chk("abort_drained", {sl_active, rvalid}, 2'b00);
    chk("abort_words", words_seen - base, 4);
    chk("abort_idle", {done, error, arvalid, rready}, 4'b0000);
    chk("abort_bursts_left", exp_bursts.size(), 0);
    tick();
    start_job(32'h0000_2000, 32'd24, 1000);   finish_job(1'b1, 1'b0, 1);

    sl_rand = 1'b1; nmode = 2;
    for (int j = 0; j < 8; j++) begin
      r = $urandom;
      a = {r[31:12], 12'd0} + (32'd4096 - 32'd4 * 32'($urandom_range(1, 48)));
      start_job(a, 32'($urandom_range(1, 60)), 1000);
      finish_job(1'b1, 1'b0, 1);
    end
    sl_rand = 1'b0; nmode = 0;

    // Asynchronous reset in the middle of a burst.
    base = words_seen;
    start_job(32'h0000_5000, 32'd32, 1000);
    t = 0;
    while (words_seen - base < 5 && t < 1000) begin tick(); t++; end
    #1;
    rst = 1'b1;
    #1;
    chk("reset_mid_data", {done, error, data_valid, arvalid, rready, araddr, arlen, data},
        {5'd0, 32'd0, 8'd0, 32'd0});
    enable = 1'b0;
    exp_words.delete();
    exp_bursts.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    start_job(32'h0000_8000, 32'd20, 1000);   finish_job(1'b1, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
